// File: rtl/rot_mailbox_pkg.sv
// Register map, FSM states and response codes of the RoT mailbox.
package rot_mailbox_pkg;
   localparam logic [2:0] CTRL_IDX = 3'd7;
   localparam int unsigned HOST_DB = 0;
   localparam int unsigned ROT_CLR = 1;

   localparam axi_pkg::resp_t RspOkay = axi_pkg::RESP_OKAY;
   localparam axi_pkg::resp_t RspSlvErr = axi_pkg::RESP_SLVERR;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_e;
endpackage

// File: rtl/tlul2axi_pkg.sv
// AXI response encodings and the RoT slave-port bundle types.
// Shared by the RoT crossbar and the blocks hanging off its AXI port.
package axi_pkg;
   typedef logic [1:0] resp_t;
   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;
endpackage

package tlul2axi_pkg;
   localparam int unsigned AXI_SLV_PORT_DATA_WIDTH = 64;
   localparam int unsigned AXI_ADDR_WIDTH = 32;
   localparam int unsigned AXI_ID_WIDTH = 4;
   localparam int unsigned AXI_STRB_WIDTH = AXI_SLV_PORT_DATA_WIDTH / 8;

   typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
   typedef logic [AXI_ID_WIDTH-1:0] id_t;
   typedef logic [AXI_SLV_PORT_DATA_WIDTH-1:0] data_t;
   typedef logic [AXI_STRB_WIDTH-1:0] strb_t;

   typedef struct packed {
      id_t         id;
      addr_t       addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [5:0]  atop;
      logic        user;
   } aw_chan_t;

   typedef struct packed {
      data_t       data;
      strb_t       strb;
      logic        last;
      logic        user;
   } w_chan_t;

   typedef struct packed {
      id_t           id;
      axi_pkg::resp_t resp;
      logic          user;
   } b_chan_t;

   typedef struct packed {
      id_t         id;
      addr_t       addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        user;
   } ar_chan_t;

   typedef struct packed {
      id_t           id;
      data_t         data;
      axi_pkg::resp_t resp;
      logic          last;
      logic          user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } slv_req_t;

   typedef struct packed {
      logic     aw_ready;
      logic     ar_ready;
      logic     w_ready;
      logic     b_valid;
      b_chan_t  b;
      logic     r_valid;
      r_chan_t  r;
   } slv_rsp_t;
endpackage

// File: rtl/rot_mailbox_regs.sv
// Mailbox payload words, the two doorbell flags and their priority.
module rot_mailbox_regs
   import rot_mailbox_pkg::*;
#(
   parameter int unsigned NumDataWords = 4,
   parameter int unsigned DataWidth = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          we_i,
   input  logic [2:0]                    widx_i,
   input  logic [DataWidth-1:0]          wdata_i,
   input  logic [DataWidth/8-1:0]        wstrb_i,
   output logic                          werr_o,
   input  logic [2:0]                    ridx_i,
   output logic [DataWidth-1:0]          rdata_o,
   output logic                          rerr_o,
   input  logic                          host_doorbell_i,
   input  logic                          host_ack_i,
   output logic                          irq_rot_o,
   output logic                          irq_host_o,
   output logic [NumDataWords*DataWidth-1:0] mbox_data_o
);
   localparam logic [2:0] NumW = 3'(NumDataWords);

   logic [DataWidth-1:0] data_q [NumDataWords];
   logic host_q, host_d;
   logic rot_q, rot_d;
   logic ctrl_we;

   assign ctrl_we = we_i && (widx_i == CTRL_IDX) && wstrb_i[0];
   assign werr_o = !((widx_i == CTRL_IDX) || (widx_i < NumW));

   // Setting a flag wins over clearing it in the same cycle.
   always_comb begin
      host_d = host_q;
      if (host_ack_i) host_d = 1'b0;
      if (ctrl_we && wdata_i[HOST_DB]) host_d = 1'b1;
      rot_d = rot_q;
      if (ctrl_we && wdata_i[ROT_CLR]) rot_d = 1'b0;
      if (host_doorbell_i) rot_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         host_q <= 1'b0;
         rot_q  <= 1'b0;
         for (int i = 0; i < NumDataWords; i++) data_q[i] <= '0;
      end else begin
         host_q <= host_d;
         rot_q  <= rot_d;
         for (int i = 0; i < NumDataWords; i++) begin
            if (we_i && (widx_i == 3'(i))) begin
               for (int b = 0; b < DataWidth/8; b++) begin
                  if (wstrb_i[b]) data_q[i][8*b +: 8] <= wdata_i[8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      rerr_o  = 1'b1;
      if (ridx_i == CTRL_IDX) begin
         rdata_o[HOST_DB] = host_q;
         rdata_o[ROT_CLR] = rot_q;
         rerr_o = 1'b0;
      end
      for (int i = 0; i < NumDataWords; i++) begin
         if (ridx_i == 3'(i)) begin
            rdata_o = data_q[i];
            rerr_o  = 1'b0;
         end
      end
   end

   for (genvar i = 0; i < NumDataWords; i++) begin : g_out
      assign mbox_data_o[i*DataWidth +: DataWidth] = data_q[i];
   end

   assign irq_rot_o  = rot_q;
   assign irq_host_o = host_q;
endmodule

// File: rtl/rot_mailbox.sv
// AXI4 slave front end of the RoT/host doorbell mailbox.
module rot_mailbox
   import rot_mailbox_pkg::*;
#(
   parameter int unsigned NumDataWords = 4,
   localparam int unsigned DataWidth = tlul2axi_pkg::AXI_SLV_PORT_DATA_WIDTH,
   localparam int unsigned IdxLsb = $clog2(DataWidth/8)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  tlul2axi_pkg::slv_req_t        axi_req_i,
   output tlul2axi_pkg::slv_rsp_t        axi_rsp_o,
   input  logic                          host_doorbell_i,
   input  logic                          host_ack_i,
   output logic                          irq_rot_o,
   output logic                          irq_host_o,
   output logic [NumDataWords*DataWidth-1:0] mbox_data_o
);
   wr_state_e wstate_q;
   rd_state_e rstate_q;
   logic aw_ready_q, w_ready_q, b_valid_q;
   logic ar_ready_q, r_valid_q;
   tlul2axi_pkg::b_chan_t b_q;
   tlul2axi_pkg::r_chan_t r_q;
   tlul2axi_pkg::id_t wid_q;
   logic [2:0] widx_q;
   logic werr_q;
   logic [7:0] rcnt_q;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic we, map_werr, map_rerr;
   logic [2:0] ridx;
   logic [DataWidth-1:0] rdata;
   logic unused_req;

   assign aw_hs = axi_req_i.aw_valid && aw_ready_q;
   assign w_hs  = axi_req_i.w_valid && w_ready_q;
   assign b_hs  = b_valid_q && axi_req_i.b_ready;
   assign ar_hs = axi_req_i.ar_valid && ar_ready_q;
   assign r_hs  = r_valid_q && axi_req_i.r_ready;
   assign ridx  = axi_req_i.ar.addr[IdxLsb+2:IdxLsb];
   assign we    = w_hs && axi_req_i.w.last && !werr_q;
   assign unused_req = ^axi_req_i;

   rot_mailbox_regs #(
      .NumDataWords(NumDataWords),
      .DataWidth   (DataWidth)
   ) u_regs (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .we_i           (we),
      .widx_i         (widx_q),
      .wdata_i        (axi_req_i.w.data),
      .wstrb_i        (axi_req_i.w.strb),
      .werr_o         (map_werr),
      .ridx_i         (ridx),
      .rdata_o        (rdata),
      .rerr_o         (map_rerr),
      .host_doorbell_i(host_doorbell_i),
      .host_ack_i     (host_ack_i),
      .irq_rot_o      (irq_rot_o),
      .irq_host_o     (irq_host_o),
      .mbox_data_o    (mbox_data_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wstate_q   <= W_IDLE;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         b_q        <= '0;
         wid_q      <= '0;
         widx_q     <= '0;
         werr_q     <= 1'b0;
      end else begin
         unique case (wstate_q)
            W_IDLE: begin
               aw_ready_q <= 1'b1;
               if (aw_hs) begin
                  aw_ready_q <= 1'b0;
                  w_ready_q  <= 1'b1;
                  wid_q      <= axi_req_i.aw.id;
                  widx_q     <= axi_req_i.aw.addr[IdxLsb+2:IdxLsb];
                  werr_q     <= (axi_req_i.aw.len != '0) ||
                                (axi_req_i.aw.atop != '0);
                  wstate_q   <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs && axi_req_i.w.last) begin
                  w_ready_q <= 1'b0;
                  b_valid_q <= 1'b1;
                  b_q.id    <= wid_q;
                  b_q.resp  <= (werr_q || map_werr) ? RspSlvErr : RspOkay;
                  wstate_q  <= W_RESP;
               end
            end
            W_RESP: begin
               if (b_hs) begin
                  b_valid_q  <= 1'b0;
                  aw_ready_q <= 1'b1;
                  wstate_q   <= W_IDLE;
               end
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end

   // Bursts return zero data with SLVERR; rcnt_q counts beats still owed.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rstate_q   <= R_IDLE;
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
         r_q        <= '0;
         rcnt_q     <= '0;
      end else begin
         unique case (rstate_q)
            R_IDLE: begin
               ar_ready_q <= 1'b1;
               if (ar_hs) begin
                  ar_ready_q <= 1'b0;
                  r_valid_q  <= 1'b1;
                  r_q.id     <= axi_req_i.ar.id;
                  rcnt_q     <= axi_req_i.ar.len;
                  rstate_q   <= R_DATA;
                  if (axi_req_i.ar.len == '0) begin
                     r_q.data <= rdata;
                     r_q.resp <= map_rerr ? RspSlvErr : RspOkay;
                     r_q.last <= 1'b1;
                  end else begin
                     r_q.data <= '0;
                     r_q.resp <= RspSlvErr;
                     r_q.last <= 1'b0;
                  end
               end
            end
            R_DATA: begin
               if (r_hs) begin
                  if (r_q.last) begin
                     r_valid_q  <= 1'b0;
                     ar_ready_q <= 1'b1;
                     rstate_q   <= R_IDLE;
                  end else begin
                     rcnt_q   <= rcnt_q - 8'd1;
                     r_q.last <= (rcnt_q == 8'd1);
                  end
               end
            end
            default: rstate_q <= R_IDLE;
         endcase
      end
   end

   always_comb begin
      axi_rsp_o          = '0;
      axi_rsp_o.aw_ready = aw_ready_q;
      axi_rsp_o.w_ready  = w_ready_q;
      axi_rsp_o.b_valid  = b_valid_q;
      axi_rsp_o.b        = b_q;
      axi_rsp_o.ar_ready = ar_ready_q;
      axi_rsp_o.r_valid  = r_valid_q;
      axi_rsp_o.r        = r_q;
   end
endmodule

// File: tb/tb_rot_mailbox.sv
// Directed bench for the RoT mailbox: data, doorbells, errors, reset.
module tb_rot_mailbox;
   import tlul2axi_pkg::*;

   localparam int unsigned NW = 4;
   localparam int TO = 50;

   logic clk = 1'b0;
   logic rst;
   slv_req_t req;
   slv_rsp_t rsp;
   logic db, ack;
   logic irq_rot, irq_host;
   logic [NW*64-1:0] mbox;

   int n_cmp = 0;
   int n_err = 0;

   logic [1:0] resp;
   logic [3:0] bid;
   logic h_aft, r_aft;

   always #5 clk = ~clk;

   rot_mailbox #(.NumDataWords(NW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .axi_req_i      (req),
      .axi_rsp_o      (rsp),
      .host_doorbell_i(db),
      .host_ack_i     (ack),
      .irq_rot_o      (irq_rot),
      .irq_host_o     (irq_host),
      .mbox_data_o    (mbox)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic axi_wr(input string tag, input logic [31:0] addr,
                         input logic [63:0] data, input logic [7:0] strb,
                         input logic [7:0] len, input logic [5:0] atop,
                         input logic [3:0] id, input logic ack_l,
                         input logic db_l, input int hold,
                         output logic [1:0] rs, output logic [3:0] ri,
                         output logic ha, output logic ra);
      int t;
      req.aw = '0;
      req.aw.addr = addr;
      req.aw.len = len;
      req.aw.atop = atop;
      req.aw.id = id;
      req.aw_valid = 1'b1;
      t = 0;
      while (!rsp.aw_ready && t < TO) begin @(negedge clk); t++; end
      if (t >= TO) chk({tag, ".aw_to"}, rsp.aw_ready, 1);
      @(negedge clk);
      req.aw_valid = 1'b0;
      ha = 1'b0;
      ra = 1'b0;
      for (int b = 0; b <= len; b++) begin
         req.w = '0;
         req.w.data = data;
         req.w.strb = strb;
         req.w.last = (b == len);
         req.w_valid = 1'b1;
         t = 0;
         while (!rsp.w_ready && t < TO) begin @(negedge clk); t++; end
         if (t >= TO) chk({tag, ".w_to"}, rsp.w_ready, 1);
         if (b == len) begin
            ack = ack_l;
            db = db_l;
         end
         @(negedge clk);
         req.w_valid = 1'b0;
         ack = 1'b0;
         db = 1'b0;
         ha = irq_host;
         ra = irq_rot;
      end
      t = 0;
      while (!rsp.b_valid && t < TO) begin @(negedge clk); t++; end
      if (t >= TO) chk({tag, ".b_to"}, rsp.b_valid, 1);
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         chk({tag, ".bhold"}, rsp.b_valid, 1);
      end
      rs = rsp.b.resp;
      ri = rsp.b.id;
      req.b_ready = 1'b1;
      @(negedge clk);
      req.b_ready = 1'b0;
   endtask

   task automatic axi_rd(input string tag, input logic [31:0] addr,
                         input logic [7:0] len, input logic [3:0] id,
                         input logic [63:0] exp_d, input logic [1:0] exp_r,
                         input int hold);
      int t;
      req.ar = '0;
      req.ar.addr = addr;
      req.ar.len = len;
      req.ar.id = id;
      req.ar_valid = 1'b1;
      t = 0;
      while (!rsp.ar_ready && t < TO) begin @(negedge clk); t++; end
      if (t >= TO) chk({tag, ".ar_to"}, rsp.ar_ready, 1);
      @(negedge clk);
      req.ar_valid = 1'b0;
      chk({tag, ".lat"}, rsp.r_valid, 1);
      for (int b = 0; b <= len; b++) begin
         t = 0;
         while (!rsp.r_valid && t < TO) begin @(negedge clk); t++; end
         if (t >= TO) chk({tag, ".r_to"}, rsp.r_valid, 1);
         if (b == 0 && hold > 0) begin
            repeat (hold) @(negedge clk);
            chk({tag, ".rhold"}, rsp.r_valid, 1);
         end
         chk({tag, ".data"}, rsp.r.data, exp_d);
         chk({tag, ".resp"}, rsp.r.resp, exp_r);
         chk({tag, ".last"}, rsp.r.last, (b == len));
         chk({tag, ".id"}, rsp.r.id, id);
         req.r_ready = 1'b1;
         @(negedge clk);
         req.r_ready = 1'b0;
      end
      chk({tag, ".rdone"}, rsp.r_valid, 0);
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      db = 1'b0;
      ack = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst.aw_ready", rsp.aw_ready, 0);
      chk("rst.b_valid", rsp.b_valid, 0);
      chk("rst.r_valid", rsp.r_valid, 0);
      chk("rst.irq", {irq_rot, irq_host}, 0);
      chk("rst.mbox", mbox[63:0] | mbox[127:64], 0);
      @(negedge clk);
      chk("idle.ready", {rsp.aw_ready, rsp.ar_ready}, 2'b11);

      // data word round trip
      axi_wr("t1w", 32'h08, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0, 4'd5,
             0, 0, 0, resp, bid, h_aft, r_aft);
      chk("t1.bresp", resp, 2'b00);
      chk("t1.bid", bid, 4'd5);
      chk("t1.mbox1", mbox[127:64], 64'hDEADBEEF_CAFEF00D);
      axi_rd("t1r", 32'h08, 0, 4'd3, 64'hDEADBEEF_CAFEF00D, 2'b00, 0);

      // byte strobes
      axi_wr("t1s0", 32'h10, 64'h11223344_55667788, 8'h0F, 0, 0, 4'd1,
             0, 0, 0, resp, bid, h_aft, r_aft);
      axi_wr("t1s1", 32'h10, 64'hAAAAAAAA_AAAAAAAA, 8'hF0, 0, 0, 4'd2,
             0, 0, 0, resp, bid, h_aft, r_aft);
      axi_rd("t1sr", 32'h10, 0, 4'd4, 64'hAAAAAAAA_55667788, 2'b00, 0);

      // host flag: set, ack, set-vs-ack
      axi_wr("t2a", 32'h38, 64'h1, 8'h01, 0, 0, 4'd6,
             0, 0, 0, resp, bid, h_aft, r_aft);
      chk("t2.set", h_aft, 1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("t2.ack", irq_host, 0);
      axi_wr("t2b", 32'h38, 64'h1, 8'h01, 0, 0, 4'd6,
             1, 0, 0, resp, bid, h_aft, r_aft);
      chk("t2.set_wins", h_aft, 1);
      axi_wr("t2c", 32'h38, 64'h0, 8'h01, 0, 0, 4'd6,
             0, 0, 0, resp, bid, h_aft, r_aft);
      chk("t2.wr0", irq_host, 1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;

      // RoT flag: doorbell, read, clear, doorbell-vs-clear
      db = 1'b1;
      @(negedge clk);
      db = 1'b0;
      chk("t3.db", irq_rot, 1);
      axi_rd("t3r", 32'h38, 0, 4'd7, 64'h2, 2'b00, 0);
      axi_wr("t3n", 32'h38, 64'h2, 8'h02, 0, 0, 4'd0,
             0, 0, 0, resp, bid, h_aft, r_aft);
      chk("t3.nostrb", r_aft, 1);
      axi_wr("t3c", 32'h38, 64'h2, 8'h01, 0, 0, 4'd0,
             0, 0, 0, resp, bid, h_aft, r_aft);
      chk("t3.clr", r_aft, 0);
      axi_wr("t3d", 32'h38, 64'h2, 8'h01, 0, 0, 4'd0,
             0, 1, 0, resp, bid, h_aft, r_aft);
      chk("t3.set_wins", r_aft, 1);
      chk("t3.host", h_aft, 0);

      // bursts and atomics
      axi_rd("t4r", 32'h08, 8'd3, 4'd9, 64'h0, 2'b10, 0);
      axi_wr("t4w", 32'h08, 64'h1111_1111, 8'hFF, 8'd2, 0, 4'd8,
             0, 0, 0, resp, bid, h_aft, r_aft);
      chk("t4w.resp", resp, 2'b10);
      chk("t4w.bid", bid, 4'd8);
      chk("t4w.mbox1", mbox[127:64], 64'hDEADBEEF_CAFEF00D);
      axi_wr("t4a", 32'h08, 64'h2222_2222, 8'hFF, 0, 6'h20, 4'd2,
             0, 0, 0, resp, bid, h_aft, r_aft);
      chk("t4a.resp", resp, 2'b10);
      chk("t4a.mbox1", mbox[127:64], 64'hDEADBEEF_CAFEF00D);

      // unmapped index, back-pressure, aliasing
      axi_wr("t5w", 32'h28, 64'h1234, 8'hFF, 0, 0, 4'd3,
             0, 0, 5, resp, bid, h_aft, r_aft);
      chk("t5w.resp", resp, 2'b10);
      chk("t5w.bid", bid, 4'd3);
      chk("t5.mbox0", mbox[63:0], 0);
      chk("t5.mbox1", mbox[127:64], 64'hDEADBEEF_CAFEF00D);
      chk("t5.mbox2", mbox[191:128], 64'hAAAAAAAA_55667788);
      chk("t5.mbox3", mbox[255:192], 0);
      axi_rd("t5r", 32'h28, 0, 4'd1, 64'h0, 2'b10, 5);
      axi_rd("t5al", 32'h48, 0, 4'd2, 64'hDEADBEEF_CAFEF00D, 2'b00, 0);

      // reset in the middle of a write
      axi_wr("t6h", 32'h38, 64'h1, 8'h01, 0, 0, 4'd0,
             0, 0, 0, resp, bid, h_aft, r_aft);
      chk("t6.pre_irq", {irq_rot, irq_host}, 2'b11);
      req.aw = '0;
      req.aw.addr = 32'h08;
      req.aw_valid = 1'b1;
      begin
         int t;
         t = 0;
         while (!rsp.aw_ready && t < TO) begin @(negedge clk); t++; end
         if (t >= TO) chk("t6.aw_to", rsp.aw_ready, 1);
      end
      @(negedge clk);
      req.aw_valid = 1'b0;
      chk("t6.in_wdata", rsp.w_ready, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6.b_valid", rsp.b_valid, 0);
      chk("t6.w_ready", rsp.w_ready, 0);
      chk("t6.irq", {irq_rot, irq_host}, 0);
      chk("t6.mbox1", mbox[127:64], 0);
      chk("t6.mbox2", mbox[191:128], 0);
      @(negedge clk);
      chk("t6.aw_ready", rsp.aw_ready, 1);
      chk("t6.b_valid2", rsp.b_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
